compression_engine_pipe: RTL

COMPRESSION_ENGINE_PIPE -- requirements
Module: compression_engine_pipe

---
 rtl/compression_engine_pipe.sv | 124 ++++++++++++
 1 files changed

// File: rtl/compression_engine_pipe.sv
// Two-stage integer-to-float-style compressor: leading-one detect, then
// mantissa round/saturate, with valid/ready flow control and a sat counter.
module compression_engine_pipe #(
  parameter int NUM_W  = 24,
  parameter int MANT_W = 12,
  parameter int CNT_W  = 16,
  localparam int EMAX  = NUM_W - MANT_W,
  localparam int EXP_W = $clog2(EMAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [NUM_W-1:0]  num_i,
  input  logic              round_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [MANT_W-1:0] mantissa_o,
  output logic [EXP_W-1:0]  exponent_o,
  output logic              sat_o,
  output logic [CNT_W-1:0]  sat_cnt_o,
  input  logic              sat_clr_i
);

  logic              v1_q, v2_q;
  logic [NUM_W-1:0]  num1_q;
  logic              rnd1_q;
  logic [EXP_W-1:0]  e1_d, e1_q;
  logic [MANT_W-1:0] mant_d, mant_q;
  logic [EXP_W-1:0]  exp_d, exp_q;
  logic              sat_d, sat_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              adv1, adv2;

  assign adv2        = ~v2_q | out_ready_i;
  assign adv1        = ~v1_q | adv2;
  assign in_ready_o  = adv1;
  assign out_valid_o = v2_q;
  assign mantissa_o  = mant_q;
  assign exponent_o  = exp_q;
  assign sat_o       = sat_q;
  assign sat_cnt_o   = cnt_q;

  // Pre-round exponent from the highest set bit above the mantissa field.
  always_comb begin
    e1_d = '0;
    for (int i = MANT_W; i < NUM_W; i++)
      if (num_i[i]) e1_d = EXP_W'(i - MANT_W + 1);
  end

  logic [NUM_W-1:0]  sh_m, sh_r;
  logic [MANT_W-1:0] m_t;
  logic              rb;
  logic [MANT_W:0]   sum;
  logic [EXP_W:0]    e_inc;

  always_comb begin
    sh_m   = num1_q >> e1_q;
    sh_r   = num1_q >> (e1_q - EXP_W'(1));
    m_t    = sh_m[MANT_W-1:0];
    rb     = rnd1_q & (e1_q != '0) & sh_r[0];
    sum    = {1'b0, m_t} + (MANT_W+1)'(rb);
    e_inc  = {1'b0, e1_q} + (EXP_W+1)'(1);
    mant_d = sum[MANT_W-1:0];
    exp_d  = e1_q;
    sat_d  = 1'b0;
    if (sum[MANT_W]) begin
      if (e_inc > (EXP_W+1)'(EMAX)) begin
        mant_d = '1;
        exp_d  = EXP_W'(EMAX);
        sat_d  = 1'b1;
      end else begin
        mant_d = {1'b1, {(MANT_W-1){1'b0}}};
        exp_d  = e_inc[EXP_W-1:0];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr_i)
      cnt_d = '0;
    else if (v2_q & out_ready_i & sat_q & ~&cnt_q)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q   <= 1'b0;
      num1_q <= '0;
      rnd1_q <= 1'b0;
      e1_q   <= '0;
    end else if (adv1) begin
      v1_q <= in_valid_i;
      if (in_valid_i) begin
        num1_q <= num_i;
        rnd1_q <= round_i;
        e1_q   <= e1_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2_q   <= 1'b0;
      mant_q <= '0;
      exp_q  <= '0;
      sat_q  <= 1'b0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        mant_q <= mant_d;
        exp_q  <= exp_d;
        sat_q  <= sat_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule
